ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 receive core and consumes its stream of raw Set-2 bytes.
- Decodes the E0 (extended), F0 (break) and E1 (Pause) prefix sequences into single key events {code, ext, brk}.
- Buffers events in a small first-word-fall-through (FWFT) FIFO with valid/ready handshake for the Nios game logic / PIO bridge.
- Drops keyboard controller replies and aborts stalled partial sequences on timeout.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 500000, idle clocks inside a partial sequence before abort (10 ms at 50 MHz); minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte from PS/2 core
- rx_valid  input  1  1-cycle strobe, rx_data valid; no backpressure
- evt_code  output  8  key scan code (prefixes stripped)
- evt_ext  output  1  1 = code was E0-prefixed
- evt_brk  output  1  1 = release (break), 0 = press (make)
- evt_valid  output  1  FIFO head valid
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready
- overflow  output  1  1-cycle pulse: decoded event dropped, FIFO full
- seq_abort  output  1  1-cycle pulse: partial sequence discarded by timeout
- seq_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, timeout counter=0, pause counter=0. All outputs 0 (evt_code/evt_ext/evt_brk=0).
- FSM advances only on cycles with rx_valid=1. Timeout logic is the exception (see below).
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with pause count 7.
  - Controller replies 00, AA, EE, FA, FE, FF -> discarded, stay IDLE.
  - Any other byte b -> push {b,0,0}.
- EXT:
  - F0 -> EXT_BRK; E0 -> stay EXT.
  - 12 or 59 (fake shift) -> discard, IDLE.
  - Any other byte b -> push {b,1,0}, IDLE.
- BRK:
  - E0 -> EXT (protocol error, restart); F0 -> stay BRK.
  - Any other byte b -> push {b,0,1}, IDLE.
- EXT_BRK:
  - 12 or 59 -> discard, IDLE.
  - E0 -> EXT; F0 -> stay EXT_BRK.
  - Any other byte b -> push {b,1,1}, IDLE.
- PAUSE:
  - Each byte decrements the pause count; byte contents are ignored.
  - On the byte that takes the count 1 -> 0: push {77,1,0}, IDLE.
- Latency: rx_valid high in cycle k causes the push at edge k+1. If the FIFO was empty, evt_valid=1 in cycle k+1 with the new event at the head.
- FIFO:
  - FWFT: evt_code/evt_ext/evt_brk reflect the head whenever evt_valid=1, and hold until popped.
  - Pop on evt_valid & evt_ready.
  - Push when full with no pop in the same cycle: event dropped, contents unchanged, overflow=1 for that cycle.
  - Push when full with a simultaneous pop: both occur, no overflow.
  - Push and pop on an empty FIFO: cannot occur, since evt_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Timeout:
  - Counter clears on every rx_valid and while in IDLE; increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: FSM -> IDLE, pause count cleared, seq_abort=1 for one cycle, no push.
  - rx_valid in the same cycle as terminal count: the byte is processed normally, no abort.
- Reset mid-sequence or with FIFO non-empty: everything cleared; queued events are lost.

Optional Feature:
- Macro: PS2_KEY_STATE_EN.
- Defined:
  - Adds output key_state [4:0] = {space, right, left, down, up}.
  - Codes: up E0 75, down E0 72, left E0 6B, right E0 74, space 29 (non-ext).
  - Each bit is set by the matching make and cleared by the matching break.
  - Updated at the same edge as the decode (k+1), independent of FIFO fullness and of overflow.
  - Reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Bytes 1C, F0 1C -> events {1C,0,0} then {1C,0,1}; evt_valid=1 exactly one cycle after first rx_valid.
- E0 75, E0 F0 75 with evt_ready=1 -> {75,1,0}, {75,1,1}; with PS2_KEY_STATE_EN, key_state[0] goes 1 then 0.
- E0 12 E0 70, then AA, then FA -> single event {70,1,0}; fake shift and replies are produced no events.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,1,0}, seq_busy=0 afterward.
- FIFO_DEPTH=4, evt_ready=0, send 5 make codes -> 4 queued in order, overflow pulses on the 5th. Then assert evt_ready while sending a 6th byte with the FIFO full -> no overflow, order preserved.
- TIMEOUT_CYCLES=16: F0 then silence -> seq_abort at cycle 16 after F0, FSM IDLE. Then byte 1C -> {1C,0,0} (make, not break).

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder
// Purpose  : Turns the raw PS/2 Set-2 byte stream into single key events
//            {code, ext, brk}. It collapses the E0 (extended), F0 (break) and
//            E1 (Pause) prefix sequences and drops keyboard controller
//            replies. Events are queued in a first-word-fall-through FIFO with
//            a valid/ready handshake. A partial sequence is aborted when the
//            bus stays silent for too long.
// Ports    : clk, reset (async, active-high)
//            rx_data[7:0], rx_valid          - byte strobe from the PS/2 core
//            evt_code[7:0], evt_ext, evt_brk - FIFO head event
//            evt_valid / evt_ready           - head handshake
//            overflow                        - pulse: event dropped, FIFO full
//            seq_abort                       - pulse: partial sequence timed out
//            seq_busy                        - a prefix sequence is in progress
//            key_state[4:0]                  - {space,right,left,down,up}
//                                              (only with PS2_KEY_STATE_EN)
// Options  : `define PS2_KEY_STATE_EN adds the key_state output.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       overflow,
    output logic       seq_abort,
    output logic       seq_busy
`ifdef PS2_KEY_STATE_EN
    ,
    output logic [4:0] key_state
`endif
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);

    // The abort is taken on the edge where the idle count would reach
    // TIMEOUT_CYCLES-1, so the decision is made while it holds TIMEOUT_CYCLES-2.
    localparam logic [c_TW-1:0] c_TO_TERM = c_TW'(TIMEOUT_CYCLES - 2);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_EXT     = 3'd1;
    localparam logic [2:0] c_S_BRK     = 3'd2;
    localparam logic [2:0] c_S_EXT_BRK = 3'd3;
    localparam logic [2:0] c_S_PAUSE   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [2:0]      r_pause_cnt;
    logic [2:0]      w_pause_nxt;
    logic [c_TW-1:0] r_to_cnt;
    logic            w_push;
    logic [9:0]      w_push_evt;
    logic            w_abort;
    logic            w_is_reply;
    logic            w_is_fake_shift;
    logic            r_overflow;
    logic            r_seq_abort;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    assign w_is_reply = (rx_data == 8'h00) || (rx_data == 8'hAA) ||
                        (rx_data == 8'hEE) || (rx_data == 8'hFA) ||
                        (rx_data == 8'hFE) || (rx_data == 8'hFF);
    // E0 12 / E0 59 are the "fake shift" codes some keyboards wrap around
    // extended keys; they never reach the consumer.
    assign w_is_fake_shift = (rx_data == 8'h12) || (rx_data == 8'h59);

    // ------------------------------------------------------------------
    // Prefix decoder: next state and the event to push on this byte
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pause_nxt = r_pause_cnt;
        w_push      = 1'b0;
        w_push_evt  = {rx_data, 2'b00};
        if (rx_valid) begin
            case (r_state)
                c_S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        w_state_nxt = c_S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        w_state_nxt = c_S_BRK;
                    end else if (rx_data == 8'hE1) begin
                        w_state_nxt = c_S_PAUSE;
                        w_pause_nxt = 3'd7;
                    end else if (!w_is_reply) begin
                        w_push     = 1'b1;
                        w_push_evt = {rx_data, 2'b00};
                    end
                end
                c_S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        w_state_nxt = c_S_EXT_BRK;
                    end else if (rx_data == 8'hE0) begin
                        w_state_nxt = c_S_EXT;
                    end else if (w_is_fake_shift) begin
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_push_evt  = {rx_data, 2'b10};
                        w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_BRK: begin
                    if (rx_data == 8'hE0) begin
                        w_state_nxt = c_S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        w_state_nxt = c_S_BRK;
                    end else begin
                        w_push      = 1'b1;
                        w_push_evt  = {rx_data, 2'b01};
                        w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_EXT_BRK: begin
                    if (w_is_fake_shift) begin
                        w_state_nxt = c_S_IDLE;
                    end else if (rx_data == 8'hE0) begin
                        w_state_nxt = c_S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        w_state_nxt = c_S_EXT_BRK;
                    end else begin
                        w_push      = 1'b1;
                        w_push_evt  = {rx_data, 2'b11};
                        w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_PAUSE: begin
                    // Pause has no break code: the 7 trailing bytes are
                    // swallowed and a single synthetic E0 77 make is emitted.
                    if (r_pause_cnt == 3'd1) begin
                        w_push      = 1'b1;
                        w_push_evt  = {8'h77, 2'b10};
                        w_pause_nxt = 3'd0;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_pause_nxt = r_pause_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_pause_nxt = 3'd0;
                end
            endcase
        end
    end

    // A byte arriving on the terminal cycle wins over the timeout.
    assign w_abort = (r_state != c_S_IDLE) && !rx_valid && (r_to_cnt == c_TO_TERM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_pause_cnt <= 3'd0;
            r_to_cnt    <= '0;
            r_seq_abort <= 1'b0;
        end else begin
            r_seq_abort <= w_abort;
            if (w_abort) begin
                r_state     <= c_S_IDLE;
                r_pause_cnt <= 3'd0;
                r_to_cnt    <= '0;
            end else begin
                r_state     <= w_state_nxt;
                r_pause_cnt <= w_pause_nxt;
                if (rx_valid || (r_state == c_S_IDLE)) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign evt_valid = (r_count != '0);
    assign w_pop     = evt_valid && evt_ready;
    assign w_full    = (r_count == c_FULL);
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign w_wr      = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_evt;
        end
    end

    // Stale storage is masked so the event outputs read zero while empty.
    assign {evt_code, evt_ext, evt_brk} = evt_valid ? r_mem[r_rd_ptr] : 10'd0;
    assign overflow  = r_overflow;
    assign seq_abort = r_seq_abort;
    assign seq_busy  = (r_state != c_S_IDLE);

`ifdef PS2_KEY_STATE_EN
    // Game-key level state follows every decoded event, even one the FIFO drops.
    logic [4:0] r_key_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_state <= 5'd0;
        end else if (w_push) begin
            case (w_push_evt[9:1])
                {8'h75, 1'b1}: r_key_state[0] <= !w_push_evt[0];
                {8'h72, 1'b1}: r_key_state[1] <= !w_push_evt[0];
                {8'h6B, 1'b1}: r_key_state[2] <= !w_push_evt[0];
                {8'h74, 1'b1}: r_key_state[3] <= !w_push_evt[0];
                {8'h29, 1'b0}: r_key_state[4] <= !w_push_evt[0];
                default:       r_key_state    <= r_key_state;
            endcase
        end
    end

    assign key_state = r_key_state;
`endif

endmodule
`default_nettype wire
